univ_shift_reg: RTL and testbench

//   Parametrised universal shift register: generalises the serial-in/parallel-out shift_reg with parallel load,

---
 rtl/usr_pkg.sv | 36 +++
 rtl/usr_burst_ctrl.sv | 86 ++++++++
 rtl/univ_shift_reg.sv | 61 ++++++
 tb/tb_univ_shift_reg.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types and the bit-fill helper for the universal shift register.
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_ARITH  = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic DIR_RIGHT = 1'b1;

  // Bit entering the register on a shift. Kept width-independent so the
  // datapath only has to place it at the MSB (right shift) or LSB (left shift).
  function automatic logic fill_bit(input logic [1:0] mode,
                                    input logic       dir,
                                    input logic       d,
                                    input logic       msb,
                                    input logic       lsb);
    logic f;
    f = 1'b0;
    case (mode_e'(mode))
      MODE_SHIFT:  f = d;
      MODE_ROTATE: f = (dir == DIR_RIGHT) ? lsb : msb;
      MODE_ARITH:  f = (dir == DIR_RIGHT) ? msb : 1'b0;
      default:     f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst engine: decides on which edges the datapath may shift, and counts
// down a clamped burst length, pulsing done on the final shift.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | free-running: shift whenever enabled and mode is not HOLD
//   ST_BUSY | burst active: shift when enabled, count down to terminal 1
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic            load,
  input  logic            start,
  input  logic [CNTW-1:0] len,
  output logic            shift_ok,
  output logic            busy,
  output logic            done
);

  state_e          state, state_nx;
  logic [CNTW-1:0] cnt, cnt_nx;
  logic            done_nx;
  logic            active;

  assign active = en && (mode_e'(mode) != MODE_HOLD);
  assign busy   = (state == ST_BUSY);

  // State, counter and done pulse registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      done  <= done_nx;
    end
  end

  // Next state: load aborts silently, start wins over shifting in idle,
  // and the shift that consumes the last count raises done.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    shift_ok = 1'b0;
    if (load) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len != '0) begin
              state_nx = ST_BUSY;
              cnt_nx   = (len > CNTW'(WIDTH)) ? CNTW'(WIDTH) : len;
            end else begin
              done_nx = 1'b1;
            end
          end else begin
            shift_ok = active;
          end
        end
        ST_BUSY: begin
          if (active) begin
            shift_ok = 1'b1;
            cnt_nx   = cnt - CNTW'(1);
            if (cnt == CNTW'(1)) begin
              state_nx = ST_IDLE;
              done_nx  = 1'b1;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with parallel load, rotate/arithmetic modes,
// serial out and a counted burst-shift engine for serialising words.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             d,
  input  logic             load,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic [CNTW-1:0]  len,
  output logic [WIDTH-1:0] out,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  logic             shift_ok;
  logic             fill;
  logic [WIDTH-1:0] shifted;

  usr_burst_ctrl #(
    .WIDTH(WIDTH),
    .CNTW (CNTW)
  ) u_ctrl (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .mode    (mode),
    .load    (load),
    .start   (start),
    .len     (len),
    .shift_ok(shift_ok),
    .busy    (busy),
    .done    (done)
  );

  // One-step shifted value using the current mode and direction.
  always_comb begin
    fill = fill_bit(mode, dir, d, out[WIDTH-1], out[0]);
    if (dir == DIR_RIGHT) shifted = {fill, out[WIDTH-1:1]};
    else                  shifted = {out[WIDTH-2:0], fill};
  end

  // Register contents: parallel load beats any shift the controller allows.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         out <= '0;
    else if (load)     out <= pdata;
    else if (shift_ok) out <= shifted;
  end

  assign sout = (dir == DIR_RIGHT) ? out[0] : out[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;
  localparam int W  = 16;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rstn, en, dir, d, load, start;
  logic [1:0]    mode;
  logic [W-1:0]  pdata;
  logic [CW-1:0] len;
  logic [W-1:0]  out;
  logic          sout, busy, done;

  typedef struct {
    string        name;
    logic [W-1:0] out;
    logic         busy;
    logic         done;
    logic         sout;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  event chk_ev;

  logic [W-1:0] t2a[7] = '{16'h0001, 16'h0002, 16'h0005, 16'h000A,
                           16'h0015, 16'h002A, 16'h0055};
  logic [W-1:0] t2b[4] = '{16'h802A, 16'hC015, 16'hE00A, 16'hF005};
  logic [W-1:0] stream = 16'b1010_0101_1100_0011;
  logic [W-1:0] v;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .dir  (dir),
    .mode (mode),
    .d    (d),
    .load (load),
    .pdata(pdata),
    .start(start),
    .len  (len),
    .out  (out),
    .sout (sout),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic push(input string name, input logic [W-1:0] eo,
                      input logic eb, input logic ed, input logic es);
    exp_t e;
    e.name = name; e.out = eo; e.busy = eb; e.done = ed; e.sout = es;
    sb.push_back(e);
  endtask

  task automatic tick_s(input string name, input logic [W-1:0] eo,
                        input logic eb, input logic ed, input logic es);
    @(posedge clk);
    #1;
    push(name, eo, eb, ed, es);
    @(negedge clk);
    #1;
  endtask

  task automatic tick(input string name, input logic [W-1:0] eo,
                      input logic eb, input logic ed);
    tick_s(name, eo, eb, ed, dir ? eo[0] : eo[W-1]);
  endtask

  task automatic do_load(input logic [W-1:0] val);
    load = 1'b1; pdata = val;
    tick("load", val, 1'b0, 1'b0);
    load = 1'b0;
  endtask

  // Monitor: drains expectations at each falling edge (or on demand for
  // asynchronous events) and compares against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (out !== e.out) begin
          miscompares++;
          $display("FAIL %s out: got %h want %h", e.name, out, e.out);
        end
        if (busy !== e.busy) begin
          miscompares++;
          $display("FAIL %s busy: got %b want %b", e.name, busy, e.busy);
        end
        if (done !== e.done) begin
          miscompares++;
          $display("FAIL %s done: got %b want %b", e.name, done, e.done);
        end
        if (sout !== e.sout) begin
          miscompares++;
          $display("FAIL %s sout: got %b want %b", e.name, sout, e.sout);
        end
      end
    end
  end

  initial begin
    rstn = 1'b0; en = 1'b0; dir = 1'b0; d = 1'b0; mode = 2'b00;
    load = 1'b0; pdata = '0; start = 1'b0; len = '0;
    #1;
    push("reset_init", 16'h0000, 1'b0, 1'b0, 1'b0);
    -> chk_ev;
    @(negedge clk); #1;
    rstn = 1'b1;

    // SHIFT left with alternating serial input, then right with d=1
    en = 1'b1; mode = 2'b00; dir = 1'b0;
    for (int i = 0; i < 7; i++) begin
      d = ~i[0];
      tick("shl", t2a[i], 1'b0, 1'b0);
    end
    dir = 1'b1; d = 1'b1;
    for (int i = 0; i < 4; i++) tick("shr", t2b[i], 1'b0, 1'b0);

    // ROTATE
    do_load(16'h8001);
    mode = 2'b01; dir = 1'b0;
    tick("rotl", 16'h0003, 1'b0, 1'b0);
    dir = 1'b1;
    tick("rotr", 16'h8001, 1'b0, 1'b0);
    tick("rotr", 16'hC000, 1'b0, 1'b0);

    // ARITH
    do_load(16'h8000);
    mode = 2'b10; dir = 1'b1;
    tick("asr", 16'hC000, 1'b0, 1'b0);
    tick("asr", 16'hE000, 1'b0, 1'b0);
    tick("asr", 16'hF000, 1'b0, 1'b0);
    do_load(16'h0001);
    dir = 1'b0;
    tick("asl", 16'h0002, 1'b0, 1'b0);
    tick("asl", 16'h0004, 1'b0, 1'b0);
    tick("asl", 16'h0008, 1'b0, 1'b0);

    // Full 16-bit burst, MSB first, with a 3-cycle enable stall
    do_load(16'hA5C3);
    mode = 2'b00; dir = 1'b0; d = 1'b0;
    start = 1'b1; len = CW'(16);
    tick_s("b5_start", 16'hA5C3, 1'b1, 1'b0, stream[15]);
    start = 1'b0;
    v = 16'hA5C3;
    for (int k = 1; k < 16; k++) begin
      if (k == 9) begin
        en = 1'b0;
        for (int s = 0; s < 3; s++)
          tick_s("b5_stall", v << 8, 1'b1, 1'b0, stream[7]);
        en = 1'b1;
      end
      tick_s("b5_shift", v << k, 1'b1, 1'b0, stream[15-k]);
    end
    tick_s("b5_last", 16'h0000, 1'b0, 1'b1, 1'b0);
    en = 1'b0;
    tick("b5_after", 16'h0000, 1'b0, 1'b0);

    // Zero-length burst
    do_load(16'h1234);
    en = 1'b1; start = 1'b1; len = '0;
    tick("len0", 16'h1234, 1'b0, 1'b1);
    start = 1'b0; en = 1'b0;
    tick("len0_after", 16'h1234, 1'b0, 1'b0);

    // Over-length burst clamps to 16 shifts, with a HOLD stall
    en = 1'b1; start = 1'b1; len = CW'(20);
    tick("clamp_start", 16'h1234, 1'b1, 1'b0);
    start = 1'b0;
    v = 16'h1234;
    for (int k = 1; k <= 16; k++) begin
      if (k == 8) begin
        mode = 2'b11;
        tick("clamp_hold", v << 7, 1'b1, 1'b0);
        mode = 2'b00;
      end
      if (k < 16) tick("clamp_shift", v << k, 1'b1, 1'b0);
      else        tick("clamp_last", 16'h0000, 1'b0, 1'b1);
    end
    en = 1'b0;
    tick("clamp_after", 16'h0000, 1'b0, 1'b0);

    // Load aborts a burst on its 5th shift: no done
    do_load(16'h00FF);
    en = 1'b1; start = 1'b1; len = CW'(20);
    tick("abort_start", 16'h00FF, 1'b1, 1'b0);
    start = 1'b0;
    v = 16'h00FF;
    for (int k = 1; k < 5; k++) tick("abort_shift", v << k, 1'b1, 1'b0);
    load = 1'b1; pdata = 16'hBEEF;
    tick("abort_load", 16'hBEEF, 1'b0, 1'b0);
    load = 1'b0; en = 1'b0;
    tick("abort_after", 16'hBEEF, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a burst
    do_load(16'hFFFF);
    en = 1'b1; start = 1'b1; len = CW'(16);
    tick("rst_pre", 16'hFFFF, 1'b1, 1'b0);
    start = 1'b0; en = 1'b0;
    tick("rst_pre_hold", 16'hFFFF, 1'b1, 1'b0);
    rstn = 1'b0;
    #1;
    push("rst_mid", 16'h0000, 1'b0, 1'b0, 1'b0);
    -> chk_ev;
    #1;

    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
